ava_scanout: RTL

Display-side consumer of the AVA pixel FIFO. Pops pixels in raster order (filled by the coordinate-generating controller), generates VGA-style horizontal/vertical timing and drives registered RGB, sync and data-enable to the video output pins. Sits between the pixel FIFO read port and the board video DAC/connector, in the same clock domain as the FIFO read side.

---
 rtl/ava_scanout_if.sv | 12 +
 rtl/ava_scanout.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ava_scanout_if.sv
// FIFO read-port bundle between the AVA pixel FIFO (slave side drives data)
// and the scanout engine (master side issues pops).
interface ava_scanout_if #(
  parameter int PIXEL_BITS = 12
) ();
  logic [PIXEL_BITS-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_rd;

  modport master (input fifo_rdata, input fifo_empty, output fifo_rd);
  modport slave  (output fifo_rdata, output fifo_empty, input fifo_rd);
endinterface

// File: rtl/ava_scanout.sv
// Video scanout: raster timing generator that pops FIFO pixels on visible
// pixel ticks and drives registered RGB/sync/DE to the output pins.
module ava_scanout #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 4,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIXEL_BITS  = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ava_scanout_if.master         fifo,
  output logic [PIXEL_BITS-1:0] rgb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  frame_start,
  output logic                  underflow,
  input  logic                  underflow_clr
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int HX_W    = H_W + 1;
  localparam int VX_W    = V_W + 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  // One extra bit so sync-end compares stay correct when a back porch is 0
  localparam logic [HX_W-1:0]  H_VIS    = HX_W'(H_VISIBLE);
  localparam logic [HX_W-1:0]  H_SS     = HX_W'(H_VISIBLE + H_FRONT);
  localparam logic [HX_W-1:0]  H_SE     = HX_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VX_W-1:0]  V_VIS    = VX_W'(V_VISIBLE);
  localparam logic [VX_W-1:0]  V_SS     = VX_W'(V_VISIBLE + V_FRONT);
  localparam logic [VX_W-1:0]  V_SE     = VX_W'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [H_W-1:0]        h_cnt_q, h_cnt_d;
  logic [V_W-1:0]        v_cnt_q, v_cnt_d;
  logic [PIXEL_BITS-1:0] rgb_q, rgb_d;
  logic                  de_q, de_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underflow_q, underflow_d;

  logic tick, visible, hs_pulse, vs_pulse, at_origin, pop, starve;
  logic [HX_W-1:0] h_ext;
  logic [VX_W-1:0] v_ext;

  // Timing decode
  always_comb begin
    h_ext     = {1'b0, h_cnt_q};
    v_ext     = {1'b0, v_cnt_q};
    tick      = (div_q == DIV_LAST);
    visible   = (h_ext < H_VIS) && (v_ext < V_VIS);
    hs_pulse  = (h_ext >= H_SS) && (h_ext < H_SE);
    vs_pulse  = (v_ext >= V_SS) && (v_ext < V_SE);
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_FRAME;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_FRAME && tick && at_origin && !fifo.fifo_empty)
      state_d = ACTIVE;
  end

  // FSM: outputs. Using state_d lets the (0,0) pixel that starts a frame be served.
  always_comb begin
    pop    = tick && visible && (state_d == ACTIVE) && !fifo.fifo_empty;
    starve = tick && visible && (state_d == ACTIVE) &&  fifo.fifo_empty;

    rgb_d         = rgb_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    fifo_rd_d     = pop;
    frame_start_d = tick && at_origin;
    if (tick) begin
      rgb_d   = pop ? fifo.fifo_rdata : '0;
      de_d    = pop;
      hsync_d = hs_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = vs_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // A new starve event wins over a clear in the same cycle
    if (starve)             underflow_d = 1'b1;
    else if (underflow_clr) underflow_d = 1'b0;
    else                    underflow_d = underflow_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      fifo_rd_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      fifo_rd_q     <= fifo_rd_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rgb          = rgb_q;
  assign de           = de_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign fifo.fifo_rd = fifo_rd_q;
  assign frame_start  = frame_start_q;
  assign underflow    = underflow_q;

endmodule
